debug_breakpoint_unit: RTL and testbench

- Consumes the eight debug registers (DR0-DR7) and compares enabled breakpoints against instruction fetches and data accesses.
- Also tracks single-step, task-switch trap and general-detect conditions.
- Raises a debug exception request to the exception controller and, once acknowledged, writes the status back through the debug register file's single write port (DR6, plus DR7 for GD clear).
- Sits between the execution/memory pipeline and the debug register file.

---
 rtl/debug_breakpoint_unit.sv | 211 +++++++++++++++++++++
 tb/tb_debug_breakpoint_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_breakpoint_unit.sv
// debug_breakpoint_unit
// Purpose: compares the four address breakpoints held in DR0-DR3 (controlled by DR7)
// against instruction fetches and data accesses. It also tracks single-step,
// task-switch trap and general-detect (GD) conditions. When one fires, the unit raises
// a debug exception request. Once that request is acknowledged, it writes the status
// back to DR6 and, for GD, writes DR7 with GD cleared.
// Ports:
//   clock, reset_n             clock, asynchronous active-low reset
//   DR[0:7]                    current debug register contents
//   fetch_*                    instruction-start compare inputs
//   access_*                   data-access compare inputs
//   instruction_retire,
//   single_step,
//   task_switch_trap           retire-time trap conditions
//   dr_access_valid            MOV to/from a DRn attempted
//   debug_request/fault/ack    handshake with the exception controller
//   busy                       core must stall event inputs while high
//   write_enable/index/data    single write port into the debug register file
module debug_breakpoint_unit #(
    parameter int unsigned NUM_BP = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] DR [0:7],
    input  logic        fetch_valid,
    input  logic [31:0] fetch_linear_address,
    input  logic        access_valid,
    input  logic [29:0] access_dword_address,
    input  logic [3:0]  access_byte_enable,
    input  logic        access_write,
    input  logic        instruction_retire,
    input  logic        single_step,
    input  logic        task_switch_trap,
    input  logic        dr_access_valid,
    output logic        debug_request,
    output logic        debug_fault,
    input  logic        debug_ack,
    output logic        busy,
    output logic        write_enable,
    output logic [2:0]  write_index,
    output logic [31:0] write_data
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWr6  = 2'd2,
        StWr7  = 2'd3
    } state_e;

    state_e      r_state;
    logic [3:0]  r_pending_b;
    logic [3:0]  r_stat_b;
    logic        r_stat_bd;
    logic        r_stat_bs;
    logic        r_stat_bt;
    logic        r_debug_request;
    logic        r_debug_fault;
    logic        r_busy;
    logic        r_write_enable;
    logic [2:0]  r_write_index;
    logic [31:0] r_write_data;

    logic [3:0]  w_exec_hit;
    logic [3:0]  w_data_hit;
    logic [3:0]  w_retire_b;
    logic        w_gd;
    logic        w_en;
    logic [1:0]  w_rw;
    logic [1:0]  w_len;
    logic [3:0]  w_mask;
    logic        w_rw_ok;
    logic        w_unused;

    // DR4/DR5 are aliases on real parts and carry nothing this unit needs.
    assign w_unused = ^{DR[4], DR[5]};

    assign w_gd = DR[7][13];

    // Breakpoint compares; DR values are the ones presented this cycle (pre-write).
    always_comb begin
        w_exec_hit = '0;
        w_data_hit = '0;
        w_en       = 1'b0;
        w_rw       = '0;
        w_len      = '0;
        w_mask     = '0;
        w_rw_ok    = 1'b0;
        for (int n = 0; n < NUM_BP; n++) begin
            w_en  = DR[7][2*n] | DR[7][2*n+1];
            w_rw  = DR[7][16+4*n +: 2];
            w_len = DR[7][18+4*n +: 2];
            case (w_len)
                2'b01:   w_mask = DR[n][1] ? 4'b1100 : 4'b0011;
                2'b11:   w_mask = 4'b1111;
                default: w_mask = 4'b0001 << DR[n][1:0];  // 00 and undefined 10
            endcase
            // RW=10 is undefined and never matches.
            w_rw_ok = (w_rw == 2'b11) || ((w_rw == 2'b01) && access_write);
            w_data_hit[n] = access_valid && w_en && w_rw_ok
                            && (access_dword_address == DR[n][31:2])
                            && (|(w_mask & access_byte_enable));
            w_exec_hit[n] = fetch_valid && w_en && (w_rw == 2'b00)
                            && (fetch_linear_address == DR[n]);
        end
    end

    // Data hits in the retire cycle belong to the retiring instruction.
    assign w_retire_b = r_pending_b | w_data_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= StIdle;
            r_pending_b     <= '0;
            r_stat_b        <= '0;
            r_stat_bd       <= 1'b0;
            r_stat_bs       <= 1'b0;
            r_stat_bt       <= 1'b0;
            r_debug_request <= 1'b0;
            r_debug_fault   <= 1'b0;
            r_busy          <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_index   <= '0;
            r_write_data    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (dr_access_valid && w_gd) begin
                        r_state         <= StReq;
                        r_debug_request <= 1'b1;
                        r_debug_fault   <= 1'b1;
                        r_busy          <= 1'b1;
                        r_stat_b        <= '0;
                        r_stat_bd       <= 1'b1;
                        r_stat_bs       <= 1'b0;
                        r_stat_bt       <= 1'b0;
                    end else if (|w_exec_hit) begin
                        r_state         <= StReq;
                        r_debug_request <= 1'b1;
                        r_debug_fault   <= 1'b1;
                        r_busy          <= 1'b1;
                        r_stat_b        <= w_exec_hit;
                        r_stat_bd       <= 1'b0;
                        r_stat_bs       <= 1'b0;
                        r_stat_bt       <= 1'b0;
                    end else if (instruction_retire) begin
                        if ((|w_retire_b) || single_step || task_switch_trap) begin
                            r_state         <= StReq;
                            r_debug_request <= 1'b1;
                            r_debug_fault   <= 1'b0;
                            r_busy          <= 1'b1;
                            r_stat_b        <= w_retire_b;
                            r_stat_bd       <= 1'b0;
                            r_stat_bs       <= single_step;
                            r_stat_bt       <= task_switch_trap;
                        end
                    end else begin
                        r_pending_b <= r_pending_b | w_data_hit;
                    end
                    // A retiring instruction consumes (or, on a fault, discards) its hits.
                    if (instruction_retire) begin
                        r_pending_b <= '0;
                    end
                end
                StReq: begin
                    if (debug_ack) begin
                        r_state         <= StWr6;
                        r_debug_request <= 1'b0;
                        r_debug_fault   <= 1'b0;
                        r_write_enable  <= 1'b1;
                        r_write_index   <= 3'd6;
                        // Sticky merge into DR6; software is responsible for clearing.
                        r_write_data    <= DR[6] | {16'b0, r_stat_bt, r_stat_bs, r_stat_bd,
                                                    9'b0, r_stat_b};
                    end
                end
                StWr6: begin
                    if (r_stat_bd) begin
                        r_state        <= StWr7;
                        r_write_index  <= 3'd7;
                        r_write_data   <= DR[7] & ~32'h0000_2000;
                    end else begin
                        r_state        <= StIdle;
                        r_busy         <= 1'b0;
                        r_write_enable <= 1'b0;
                        r_write_index  <= '0;
                        r_write_data   <= '0;
                    end
                end
                StWr7: begin
                    r_state        <= StIdle;
                    r_busy         <= 1'b0;
                    r_write_enable <= 1'b0;
                    r_write_index  <= '0;
                    r_write_data   <= '0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign debug_request = r_debug_request;
    assign debug_fault   = r_debug_fault;
    assign busy          = r_busy;
    assign write_enable  = r_write_enable;
    assign write_index   = r_write_index;
    assign write_data    = r_write_data;

endmodule

// File: tb/tb_debug_breakpoint_unit.sv
// tb_debug_breakpoint_unit
// Purpose: directed-vector bench for debug_breakpoint_unit with hand-computed expectations.
module tb_debug_breakpoint_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] dr [0:7];
    logic        fetch_valid;
    logic [31:0] fetch_linear_address;
    logic        access_valid;
    logic [29:0] access_dword_address;
    logic [3:0]  access_byte_enable;
    logic        access_write;
    logic        instruction_retire;
    logic        single_step;
    logic        task_switch_trap;
    logic        dr_access_valid;
    logic        debug_request;
    logic        debug_fault;
    logic        debug_ack;
    logic        busy;
    logic        write_enable;
    logic [2:0]  write_index;
    logic [31:0] write_data;

    int n_checks = 0;
    int n_fail   = 0;

    debug_breakpoint_unit #(.NUM_BP(4)) u_dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .DR                   (dr),
        .fetch_valid          (fetch_valid),
        .fetch_linear_address (fetch_linear_address),
        .access_valid         (access_valid),
        .access_dword_address (access_dword_address),
        .access_byte_enable   (access_byte_enable),
        .access_write         (access_write),
        .instruction_retire   (instruction_retire),
        .single_step          (single_step),
        .task_switch_trap     (task_switch_trap),
        .dr_access_valid      (dr_access_valid),
        .debug_request        (debug_request),
        .debug_fault          (debug_fault),
        .debug_ack            (debug_ack),
        .busy                 (busy),
        .write_enable         (write_enable),
        .write_index          (write_index),
        .write_data           (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_valid          = 1'b0;
        fetch_linear_address = '0;
        access_valid         = 1'b0;
        access_dword_address = '0;
        access_byte_enable   = '0;
        access_write         = 1'b0;
        instruction_retire   = 1'b0;
        single_step          = 1'b0;
        task_switch_trap     = 1'b0;
        dr_access_valid      = 1'b0;
        debug_ack            = 1'b0;
    endtask

    // Acknowledge a pending request; leaves the DUT in the DR6 write cycle.
    task automatic ack_req();
        debug_ack = 1'b1;
        step();
        debug_ack = 1'b0;
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < 8; i++) dr[i] = '0;
        reset_n = 1'b0;
        step();
        step();
        check("rst_req",  {31'b0, debug_request}, 32'd0);
        check("rst_flt",  {31'b0, debug_fault},   32'd0);
        check("rst_busy", {31'b0, busy},          32'd0);
        check("rst_we",   {31'b0, write_enable},  32'd0);
        check("rst_idx",  {29'b0, write_index},   32'd0);
        check("rst_data", write_data,             32'd0);
        reset_n = 1'b1;
        step();

        // Exec breakpoint on DR0.
        dr[0] = 32'h0000_1004;
        dr[7] = 32'h0000_0001;
        fetch_valid = 1'b1;
        fetch_linear_address = 32'h0000_1004;
        step();
        clear_inputs();
        check("ex_req",  {31'b0, debug_request}, 32'd1);
        check("ex_flt",  {31'b0, debug_fault},   32'd1);
        check("ex_busy", {31'b0, busy},          32'd1);
        step();
        check("ex_hold", {31'b0, debug_request}, 32'd1);
        ack_req();
        check("ex_we",   {31'b0, write_enable},  32'd1);
        check("ex_idx",  {29'b0, write_index},   32'd6);
        check("ex_data", write_data,             32'h0000_0001);
        check("ex_rq0",  {31'b0, debug_request}, 32'd0);
        step();
        check("ex_we0",  {31'b0, write_enable},  32'd0);
        check("ex_bsy0", {31'b0, busy},          32'd0);

        // Data write breakpoint on DR1 (RW=01, 4-byte length).
        dr[0] = '0;
        dr[1] = 32'h0000_2002;
        dr[7] = 32'h00D0_0004;
        access_valid = 1'b1;
        access_dword_address = 30'h800;
        access_byte_enable = 4'b0100;
        access_write = 1'b0;
        step();
        clear_inputs();
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("rd_norq", {31'b0, debug_request}, 32'd0);
        access_valid = 1'b1;
        access_dword_address = 30'h800;
        access_byte_enable = 4'b0100;
        access_write = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        check("wr_wait", {31'b0, debug_request}, 32'd0);
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("wr_req",  {31'b0, debug_request}, 32'd1);
        check("wr_trap", {31'b0, debug_fault},   32'd0);
        ack_req();
        check("wr_data", write_data,             32'h0000_0002);
        step();

        // 2-byte length at DR1=0x2002 covers byte enables 1100 only.
        dr[7] = 32'h0050_0004;
        access_valid = 1'b1;
        access_dword_address = 30'h800;
        access_byte_enable = 4'b0001;
        access_write = 1'b1;
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("l2_miss", {31'b0, debug_request}, 32'd0);
        access_valid = 1'b1;
        access_dword_address = 30'h800;
        access_byte_enable = 4'b1000;
        access_write = 1'b1;
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("l2_hit",  {31'b0, debug_request}, 32'd1);
        ack_req();
        check("l2_data", write_data,             32'h0000_0002);
        step();

        // General detect: fault, DR6 BD, then DR7 with GD cleared.
        dr[1] = '0;
        dr[7] = 32'h0000_2000;
        dr_access_valid = 1'b1;
        step();
        clear_inputs();
        check("gd_req",  {31'b0, debug_request}, 32'd1);
        check("gd_flt",  {31'b0, debug_fault},   32'd1);
        ack_req();
        check("gd_idx6", {29'b0, write_index},   32'd6);
        check("gd_d6",   write_data,             32'h0000_2000);
        step();
        check("gd_we7",  {31'b0, write_enable},  32'd1);
        check("gd_idx7", {29'b0, write_index},   32'd7);
        check("gd_d7",   write_data,             32'h0000_0000);
        check("gd_bsy",  {31'b0, busy},          32'd1);
        step();
        check("gd_bsy0", {31'b0, busy},          32'd0);
        check("gd_we0",  {31'b0, write_enable},  32'd0);

        // Single-step plus task-switch trap, existing DR6 bits preserved.
        dr[7] = '0;
        dr[6] = 32'h0000_0008;
        instruction_retire = 1'b1;
        single_step = 1'b1;
        task_switch_trap = 1'b1;
        step();
        clear_inputs();
        check("ss_req",  {31'b0, debug_request}, 32'd1);
        check("ss_trap", {31'b0, debug_fault},   32'd0);
        ack_req();
        check("ss_data", write_data,             32'h0000_C008);
        step();
        dr[6] = '0;

        // RW=10 on DR0 never matches, for data or exec.
        dr[0] = 32'h0000_5000;
        dr[7] = 32'h0002_0001;
        access_valid = 1'b1;
        access_dword_address = 30'h1400;
        access_byte_enable = 4'b0001;
        access_write = 1'b1;
        fetch_valid = 1'b1;
        fetch_linear_address = 32'h0000_5000;
        step();
        clear_inputs();
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("rw10",    {31'b0, debug_request}, 32'd0);

        // Exec hit on DR2 with retire carrying a pending DR3 data hit: fault, B=0100.
        dr[0] = '0;
        dr[2] = 32'h0000_3000;
        dr[3] = 32'h0000_4000;
        dr[7] = 32'hD000_0050;
        access_valid = 1'b1;
        access_dword_address = 30'h1000;
        access_byte_enable = 4'b0001;
        access_write = 1'b1;
        step();
        clear_inputs();
        check("px_pend", {31'b0, debug_request}, 32'd0);
        fetch_valid = 1'b1;
        fetch_linear_address = 32'h0000_3000;
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("px_req",  {31'b0, debug_request}, 32'd1);
        check("px_flt",  {31'b0, debug_fault},   32'd1);
        ack_req();
        check("px_data", write_data,             32'h0000_0004);
        step();
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("px_disc", {31'b0, debug_request}, 32'd0);

        // Asynchronous reset while in REQ, with a DR3 hit still pending.
        access_valid = 1'b1;
        access_dword_address = 30'h1000;
        access_byte_enable = 4'b0001;
        access_write = 1'b1;
        step();
        clear_inputs();
        fetch_valid = 1'b1;
        fetch_linear_address = 32'h0000_3000;
        step();
        clear_inputs();
        check("ar_req",  {31'b0, debug_request}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_rq0",  {31'b0, debug_request}, 32'd0);
        check("ar_bsy0", {31'b0, busy},          32'd0);
        check("ar_we0",  {31'b0, write_enable},  32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_nowr", {31'b0, write_enable}, 32'd0);
        end
        instruction_retire = 1'b1;
        step();
        clear_inputs();
        check("ar_pclr", {31'b0, debug_request}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
